// File: rtl/vga_ctrl_pkg.sv
// ============================================================================
// Module   : vga_timing_pkg
// Brief    : 640x480@60 Hz timing constants shared by vga_ctrl and the image stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

package vga_timing_pkg;

    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BACK   = 40;
    localparam int unsigned H_LEFT   = 8;
    localparam int unsigned H_VALID  = 640;
    localparam int unsigned H_RIGHT  = 8;
    localparam int unsigned H_FRONT  = 8;

    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BACK   = 25;
    localparam int unsigned V_TOP    = 8;
    localparam int unsigned V_VALID  = 480;
    localparam int unsigned V_BOTTOM = 8;
    localparam int unsigned V_FRONT  = 2;

    localparam logic SYNC_POL = 1'b1;

    localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_LEFT + H_VALID + H_RIGHT + H_FRONT;
    localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_TOP + V_VALID + V_BOTTOM + V_FRONT;
    localparam int unsigned H_ACT   = H_SYNC + H_BACK + H_LEFT;
    localparam int unsigned V_ACT   = V_SYNC + V_BACK + V_TOP;

    localparam int unsigned PIX_W = 10;
    localparam int unsigned RGB_W = 16;

    // Coordinate value the image stage treats as "blank".
    localparam logic [PIX_W-1:0] PIX_INVALID = 10'h3FF;

endpackage

`default_nettype wire

// File: rtl/vga_ctrl_if.sv
// ============================================================================
// Module   : vga_ctrl_if
// Brief    : Pixel request/response bus between vga_ctrl and the image stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface vga_ctrl_if;
    import vga_timing_pkg::*;

    logic [PIX_W-1:0] pix_x;
    logic [PIX_W-1:0] pix_y;
    logic [RGB_W-1:0] pix_data;

    modport master (output pix_x, output pix_y, input  pix_data);
    modport slave  (input  pix_x, input  pix_y, output pix_data);

endinterface

`default_nettype wire

// File: rtl/vga_ctrl.sv
// ============================================================================
// Module   : vga_ctrl
// Brief    : VGA timing generator; requests pixels one clock ahead of display.
// Revision : 1.0
// ============================================================================
`default_nettype none

module vga_ctrl #(
    parameter int unsigned H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int unsigned H_BACK   = vga_timing_pkg::H_BACK,
    parameter int unsigned H_LEFT   = vga_timing_pkg::H_LEFT,
    parameter int unsigned H_VALID  = vga_timing_pkg::H_VALID,
    parameter int unsigned H_RIGHT  = vga_timing_pkg::H_RIGHT,
    parameter int unsigned H_FRONT  = vga_timing_pkg::H_FRONT,
    parameter int unsigned V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int unsigned V_BACK   = vga_timing_pkg::V_BACK,
    parameter int unsigned V_TOP    = vga_timing_pkg::V_TOP,
    parameter int unsigned V_VALID  = vga_timing_pkg::V_VALID,
    parameter int unsigned V_BOTTOM = vga_timing_pkg::V_BOTTOM,
    parameter int unsigned V_FRONT  = vga_timing_pkg::V_FRONT,
    parameter logic        SYNC_POL = vga_timing_pkg::SYNC_POL
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    vga_ctrl_if.master       pix,
    output logic             hsync,
    output logic             vsync,
    output logic [15:0]      rgb,
    output logic             frame_end
);
    import vga_timing_pkg::PIX_INVALID;

    localparam int unsigned c_H_TOTAL = H_SYNC + H_BACK + H_LEFT + H_VALID + H_RIGHT + H_FRONT;
    localparam int unsigned c_V_TOTAL = V_SYNC + V_BACK + V_TOP + V_VALID + V_BOTTOM + V_FRONT;
    localparam int unsigned c_H_ACT   = H_SYNC + H_BACK + H_LEFT;
    localparam int unsigned c_V_ACT   = V_SYNC + V_BACK + V_TOP;

    localparam logic [9:0] c_H_LAST    = 10'(c_H_TOTAL - 1);
    localparam logic [9:0] c_V_LAST    = 10'(c_V_TOTAL - 1);
    localparam logic [9:0] c_H_SYNC    = 10'(H_SYNC);
    localparam logic [9:0] c_V_SYNC    = 10'(V_SYNC);
    localparam logic [9:0] c_H_VIS_BEG = 10'(c_H_ACT);
    localparam logic [9:0] c_H_VIS_END = 10'(c_H_ACT + H_VALID);
    localparam logic [9:0] c_H_REQ_BEG = 10'(c_H_ACT - 1);
    localparam logic [9:0] c_H_REQ_END = 10'(c_H_ACT - 1 + H_VALID);
    localparam logic [9:0] c_V_BEG     = 10'(c_V_ACT);
    localparam logic [9:0] c_V_END     = 10'(c_V_ACT + V_VALID);

    generate
        if ((c_H_TOTAL > 1024) || (c_V_TOTAL > 1024)) begin : g_bad_timing
            $error("vga_ctrl: H_TOTAL/V_TOTAL exceed 10-bit counter range");
        end
    endgenerate

    logic [9:0] r_cnt_h;
    logic [9:0] r_cnt_v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_h <= '0;
            r_cnt_v <= '0;
        end else if (r_cnt_h == c_H_LAST) begin
            r_cnt_h <= '0;
            r_cnt_v <= (r_cnt_v == c_V_LAST) ? 10'd0 : r_cnt_v + 10'd1;
        end else begin
            r_cnt_h <= r_cnt_h + 10'd1;
        end
    end

    logic w_v_win;
    logic w_h_vis;
    logic w_h_req;
    logic w_rgb_valid;
    logic w_pix_req;

    always_comb begin
        w_v_win     = (r_cnt_v >= c_V_BEG) && (r_cnt_v < c_V_END);
        w_h_vis     = (r_cnt_h >= c_H_VIS_BEG) && (r_cnt_h < c_H_VIS_END);
        w_h_req     = (r_cnt_h >= c_H_REQ_BEG) && (r_cnt_h < c_H_REQ_END);
        w_rgb_valid = w_v_win && w_h_vis;
        w_pix_req   = w_v_win && w_h_req;
    end

    // Request leads display by one clock to cover the image stage's register.
    assign pix.pix_x = w_pix_req ? (r_cnt_h - c_H_REQ_BEG) : PIX_INVALID;
    assign pix.pix_y = w_pix_req ? (r_cnt_v - c_V_BEG)     : PIX_INVALID;

    assign hsync     = (r_cnt_h < c_H_SYNC) ? SYNC_POL : ~SYNC_POL;
    assign vsync     = (r_cnt_v < c_V_SYNC) ? SYNC_POL : ~SYNC_POL;
    assign rgb       = w_rgb_valid ? pix.pix_data : 16'h0000;
    assign frame_end = (r_cnt_h == c_H_LAST) && (r_cnt_v == c_V_LAST);

endmodule

`default_nettype wire

// File: tb/tb_vga_ctrl.sv
// ============================================================================
// Module   : tb_vga_ctrl
// Brief    : Self-checking bench: default build plus small-timing builds of both sync polarities.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_vga_ctrl;

    localparam int DHT = 800, DVT = 525;
    localparam int SHT = 18,  SVT = 13;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mode_ff = 1'b1;
    int   checks = 0;
    int   failures = 0;
    longint tcnt;

    always #20 clk = ~clk;

    vga_ctrl_if ifa();
    vga_ctrl_if ifb();
    vga_ctrl_if ifc();

    logic        hs_a, vs_a, fe_a, hs_b, vs_b, fe_b, hs_c, vs_c, fe_c;
    logic [15:0] rgb_a, rgb_b, rgb_c;

    vga_ctrl u_a (.clk(clk), .rst_n(rst_n), .pix(ifa), .hsync(hs_a), .vsync(vs_a),
                  .rgb(rgb_a), .frame_end(fe_a));

    vga_ctrl #(.H_SYNC(4), .H_BACK(2), .H_LEFT(1), .H_VALID(8), .H_RIGHT(1), .H_FRONT(2),
               .V_SYNC(2), .V_BACK(2), .V_TOP(1), .V_VALID(6), .V_BOTTOM(1), .V_FRONT(1),
               .SYNC_POL(1'b1))
        u_b (.clk(clk), .rst_n(rst_n), .pix(ifb), .hsync(hs_b), .vsync(vs_b),
             .rgb(rgb_b), .frame_end(fe_b));

    vga_ctrl #(.H_SYNC(4), .H_BACK(2), .H_LEFT(1), .H_VALID(8), .H_RIGHT(1), .H_FRONT(2),
               .V_SYNC(2), .V_BACK(2), .V_TOP(1), .V_VALID(6), .V_BOTTOM(1), .V_FRONT(1),
               .SYNC_POL(1'b0))
        u_c (.clk(clk), .rst_n(rst_n), .pix(ifc), .hsync(hs_c), .vsync(vs_c),
             .rgb(rgb_c), .frame_end(fe_c));

    // Registered image-stage model: returns {row[5:0], col} one clock after the request.
    always @(posedge clk) begin
        ifa.pix_data <= mode_ff ? 16'hFFFF : {ifa.pix_y[5:0], ifa.pix_x};
        ifb.pix_data <= {ifb.pix_y[5:0], ifb.pix_x};
        ifc.pix_data <= {ifc.pix_y[5:0], ifc.pix_x};
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tcnt <= 0;
        else        tcnt <= tcnt + 1;
    end

    logic [15:0] qa[$];
    logic [15:0] qb[$];

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        logic [38:0] exp1, exp0;
        exp1 = {1'b1, 1'b1, 10'h3FF, 10'h3FF, 16'h0000, 1'b0};
        exp0 = {1'b0, 1'b0, 10'h3FF, 10'h3FF, 16'h0000, 1'b0};
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int pass = 0; pass < 2; pass++) begin
            checks++;
            if ({hs_a, vs_a, ifa.pix_x, ifa.pix_y, rgb_a, fe_a} !== exp1) begin
                failures++;
                $display("FAIL reset_a pass=%0d got=%h exp=%h", pass,
                         {hs_a, vs_a, ifa.pix_x, ifa.pix_y, rgb_a, fe_a}, exp1);
            end
            checks++;
            if ({hs_b, vs_b, ifb.pix_x, ifb.pix_y, rgb_b, fe_b} !== exp1) begin
                failures++;
                $display("FAIL reset_b pass=%0d got=%h exp=%h", pass,
                         {hs_b, vs_b, ifb.pix_x, ifb.pix_y, rgb_b, fe_b}, exp1);
            end
            checks++;
            if ({hs_c, vs_c, ifc.pix_x, ifc.pix_y, rgb_c, fe_c} !== exp0) begin
                failures++;
                $display("FAIL reset_c pass=%0d got=%h exp=%h", pass,
                         {hs_c, vs_c, ifc.pix_x, ifc.pix_y, rgb_c, fe_c}, exp0);
            end
            rst_n = 1'b1;
            #1;
        end
    endtask

    task automatic test_small_frames();
        int h, v, fe_cnt, hs_hi, vs_hi;
        logic ehs, evs, req, vis, efe;
        logic [9:0] ex, ey;
        logic [15:0] exp_px;
        fe_cnt = 0; hs_hi = 0; vs_hi = 0;
        qb.delete();
        apply_reset();
        for (int n = 0; n < 3 * SHT * SVT; n++) begin
            h   = int'(tcnt % SHT);
            v   = int'((tcnt / SHT) % SVT);
            ehs = (h < 4);
            evs = (v < 2);
            req = (h >= 6) && (h < 14) && (v >= 5) && (v < 11);
            vis = (h >= 7) && (h < 15) && (v >= 5) && (v < 11);
            efe = (h == SHT - 1) && (v == SVT - 1);
            ex  = req ? 10'(h - 6) : 10'h3FF;
            ey  = req ? 10'(v - 5) : 10'h3FF;
            checks++;
            if ({hs_b, vs_b, ifb.pix_x, ifb.pix_y, fe_b} !== {ehs, evs, ex, ey, efe}) begin
                failures++;
                $display("FAIL small_timing h=%0d v=%0d got=%h exp=%h", h, v,
                         {hs_b, vs_b, ifb.pix_x, ifb.pix_y, fe_b}, {ehs, evs, ex, ey, efe});
            end
            checks++;
            if ({hs_c, vs_c, ifc.pix_x, ifc.pix_y, fe_c} !== {~ehs, ~evs, ex, ey, efe}) begin
                failures++;
                $display("FAIL small_pol0 h=%0d v=%0d got=%h exp=%h", h, v,
                         {hs_c, vs_c, ifc.pix_x, ifc.pix_y, fe_c}, {~ehs, ~evs, ex, ey, efe});
            end
            if (vis) begin
                if (qb.size() == 0) exp_px = 16'hDEAD;
                else                exp_px = qb.pop_front();
            end else begin
                exp_px = 16'h0000;
            end
            checks++;
            if ((rgb_b !== exp_px) || (rgb_c !== exp_px)) begin
                failures++;
                $display("FAIL small_rgb h=%0d v=%0d got_b=%h got_c=%h exp=%h", h, v,
                         rgb_b, rgb_c, exp_px);
            end
            if (req) qb.push_back({ey[5:0], ex});
            if (fe_b === 1'b1) fe_cnt++;
            if (hs_b === 1'b1) hs_hi++;
            if (vs_b === 1'b1) vs_hi++;
            @(negedge clk);
            #1;
        end
        checks++;
        if ({fe_cnt, hs_hi, vs_hi} !== {32'd3, 32'(3 * SVT * 4), 32'(3 * 2 * SHT)}) begin
            failures++;
            $display("FAIL small_counts fe=%0d hs_hi=%0d vs_hi=%0d exp=3/%0d/%0d",
                     fe_cnt, hs_hi, vs_hi, 3 * SVT * 4, 3 * 2 * SHT);
        end
    endtask

    task automatic test_default_lines();
        int h, v, hs_hi, vs_hi, rises;
        logic ehs, evs, req, vis, prev_hs;
        logic [9:0] ex, ey;
        logic [15:0] exp_px;
        hs_hi = 0; vs_hi = 0; rises = 0; prev_hs = 1'b1;
        qa.delete();
        mode_ff = 1'b1;
        apply_reset();
        for (int n = 0; n < 37 * DHT; n++) begin
            h   = int'(tcnt % DHT);
            v   = int'((tcnt / DHT) % DVT);
            if (tcnt == 34 * DHT) mode_ff = 1'b0;
            ehs = (h < 96);
            evs = (v < 2);
            req = (h >= 143) && (h < 783) && (v >= 35) && (v < 515);
            vis = (h >= 144) && (h < 784) && (v >= 35) && (v < 515);
            ex  = req ? 10'(h - 143) : 10'h3FF;
            ey  = req ? 10'(v - 35)  : 10'h3FF;
            checks++;
            if ({hs_a, vs_a, ifa.pix_x, ifa.pix_y, fe_a} !== {ehs, evs, ex, ey, 1'b0}) begin
                failures++;
                $display("FAIL dflt_timing h=%0d v=%0d got=%h exp=%h", h, v,
                         {hs_a, vs_a, ifa.pix_x, ifa.pix_y, fe_a}, {ehs, evs, ex, ey, 1'b0});
            end
            if (v == 35 && (h == 142 || h == 143 || h == 782 || h == 783)) begin
                case (h)
                    142:     ex = 10'h3FF;
                    143:     ex = 10'd0;
                    782:     ex = 10'd639;
                    default: ex = 10'h3FF;
                endcase
                checks++;
                if (ifa.pix_x !== ex || (h == 143 && ifa.pix_y !== 10'd0)) begin
                    failures++;
                    $display("FAIL align h=%0d pix_x=%h pix_y=%h exp_x=%h", h,
                             ifa.pix_x, ifa.pix_y, ex);
                end
            end
            if (vis) begin
                if (qa.size() == 0) exp_px = 16'hDEAD;
                else                exp_px = qa.pop_front();
            end else begin
                exp_px = 16'h0000;
            end
            checks++;
            if (rgb_a !== exp_px) begin
                failures++;
                $display("FAIL dflt_rgb h=%0d v=%0d got=%h exp=%h", h, v, rgb_a, exp_px);
            end
            if (req) qa.push_back({ey[5:0], ex});
            if (hs_a === 1'b1) hs_hi++;
            if (vs_a === 1'b1) vs_hi++;
            if (hs_a === 1'b1 && prev_hs === 1'b0) rises++;
            prev_hs = hs_a;
            @(negedge clk);
            #1;
        end
        checks++;
        if ({hs_hi, vs_hi, rises} !== {32'(37 * 96), 32'd1600, 32'd36}) begin
            failures++;
            $display("FAIL dflt_sync_counts hs_hi=%0d vs_hi=%0d rises=%0d exp=%0d/1600/36",
                     hs_hi, vs_hi, rises, 37 * 96);
        end
    endtask

    task automatic test_async_reset();
        logic [38:0] exp1, exp0;
        exp1 = {1'b1, 1'b1, 10'h3FF, 10'h3FF, 16'h0000, 1'b0};
        exp0 = {1'b0, 1'b0, 10'h3FF, 10'h3FF, 16'h0000, 1'b0};
        mode_ff = 1'b1;
        for (int k = 0; k < 3; k++) begin
            repeat ($urandom_range(100, 900)) @(negedge clk);
            #7;
            rst_n = 1'b0;
            #1;
            checks++;
            if ({hs_a, vs_a, ifa.pix_x, ifa.pix_y, rgb_a, fe_a} !== exp1 ||
                {hs_b, vs_b, ifb.pix_x, ifb.pix_y, rgb_b, fe_b} !== exp1 ||
                {hs_c, vs_c, ifc.pix_x, ifc.pix_y, rgb_c, fe_c} !== exp0) begin
                failures++;
                $display("FAIL async_reset k=%0d a=%h b=%h c=%h exp=%h", k,
                         {hs_a, vs_a, ifa.pix_x, ifa.pix_y, rgb_a, fe_a},
                         {hs_b, vs_b, ifb.pix_x, ifb.pix_y, rgb_b, fe_b},
                         {hs_c, vs_c, ifc.pix_x, ifc.pix_y, rgb_c, fe_c}, exp1);
            end
            @(negedge clk);
            rst_n = 1'b1;
            repeat (4) @(negedge clk);
            #1;
            // Four clocks after release: small build at cnt_h=4, sync just dropped.
            checks++;
            if ({hs_a, hs_b, hs_c, ifb.pix_x} !== {1'b1, 1'b0, 1'b1, 10'h3FF}) begin
                failures++;
                $display("FAIL async_restart k=%0d got=%h exp=%h", k,
                         {hs_a, hs_b, hs_c, ifb.pix_x}, {1'b1, 1'b0, 1'b1, 10'h3FF});
            end
        end
    endtask

    initial begin
        test_reset();
        test_small_frames();
        test_default_lines();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
